// File: rtl/mem_txn_fsm.sv
// Flash transaction sequencer feeding mem_spi_controller: WREN/opcode/address/dummy/data/status poll.
// Optional build macro MEM_QUAD_READ_EN selects quad-output fast read (0x6B plus a dummy byte).
module mem_txn_fsm #(
    parameter int unsigned CS_GAP_CYC = 4,
    parameter int unsigned POLL_MAX   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_start,
    output logic        spi_r_w,
    output logic        spi_quad,
    output logic        spi_qed,
    input  logic        spi_done,
    output logic        spi_tx_valid,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_tx_ready,
    input  logic        spi_rx_valid,
    input  logic [7:0]  spi_rx_data,
    output logic        spi_rx_ready
);

`ifdef MEM_QUAD_READ_EN
    localparam logic [7:0] RdOpcode = 8'h6B;
    localparam bit         QuadRead = 1'b1;
`else
    localparam logic [7:0] RdOpcode = 8'h03;
    localparam bit         QuadRead = 1'b0;
`endif
    localparam int unsigned GapW = (CS_GAP_CYC > 1) ? $clog2(CS_GAP_CYC) : 1;

    typedef enum logic [3:0] {
        StIdle, StWren, StGap, StCmd, StAddr, StDummy, StData, StPollCmd, StPollRd, StFin
    } state_e;

    state_e          state_q, state_d;
    logic [23:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic            poll_phase_q, poll_phase_d;
    logic            last_q, last_d;
    logic            tx_sent_q, tx_sent_d;
    logic            req_ready_q;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      data_cnt_q, data_cnt_d;
    logic [15:0]     poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    logic tx_req, tx_hs, byte_fire, rd_last, rx_stall;

    // Byte-level datapath: what is offered to the controller and the engine in each state.
    always_comb begin
        tx_req       = 1'b0;
        spi_tx_data  = 8'h00;
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = 8'h00;
        spi_rx_ready = 1'b0;
        spi_r_w      = 1'b0;
        unique case (state_q)
            StWren: begin
                tx_req      = 1'b1;
                spi_tx_data = 8'h06;
            end
            StCmd: begin
                tx_req      = 1'b1;
                spi_tx_data = wr_q ? 8'h02 : RdOpcode;
            end
            StAddr: begin
                tx_req = 1'b1;
                unique case (byte_cnt_q)
                    2'd0:    spi_tx_data = addr_q[23:16];
                    2'd1:    spi_tx_data = addr_q[15:8];
                    default: spi_tx_data = addr_q[7:0];
                endcase
            end
            StDummy: tx_req = 1'b1;
            StData: begin
                if (wr_q) begin
                    tx_req      = wr_valid;
                    spi_tx_data = wr_data;
                    wr_ready    = spi_tx_ready && !tx_sent_q;
                end else begin
                    spi_r_w      = 1'b1;
                    rd_valid     = spi_rx_valid;
                    rd_data      = spi_rx_data;
                    spi_rx_ready = rd_ready;
                end
            end
            StPollCmd: begin
                tx_req      = 1'b1;
                spi_tx_data = 8'h05;
            end
            StPollRd: begin
                spi_r_w      = 1'b1;
                spi_rx_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign spi_tx_valid = tx_req && !tx_sent_q;
    assign tx_hs        = spi_tx_valid && spi_tx_ready;
    // A tx byte is finished only by the spi_done that follows its own handshake.
    assign byte_fire    = spi_done && (tx_sent_q || tx_hs);
    assign rd_last      = last_q || (spi_done && data_cnt_q == len_q);
    assign rx_stall     = spi_rx_valid && !rd_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wr_d         = wr_q;
        err_d        = err_q;
        poll_phase_d = poll_phase_q;
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        data_cnt_d   = data_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = '0;
        tx_sent_d    = byte_fire ? 1'b0 : (tx_hs ? 1'b1 : tx_sent_q);
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    addr_d       = req_addr;
                    len_d        = req_len;
                    wr_d         = req_wr;
                    err_d        = 1'b0;
                    poll_phase_d = 1'b0;
                    last_d       = 1'b0;
                    data_cnt_d   = '0;
                    poll_cnt_d   = '0;
                    state_d      = req_wr ? StWren : StCmd;
                end
            end
            StWren: if (byte_fire) state_d = StGap;
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GapW'(CS_GAP_CYC - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = poll_phase_q ? StPollCmd : StCmd;
                end
            end
            StCmd: begin
                byte_cnt_d = '0;
                if (byte_fire) state_d = StAddr;
            end
            StAddr: begin
                if (byte_fire) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd2) state_d = (QuadRead && !wr_q) ? StDummy : StData;
                end
            end
            StDummy: if (byte_fire) state_d = StData;
            StData: begin
                if (wr_q) begin
                    if (byte_fire) begin
                        data_cnt_d = data_cnt_q + 1'b1;
                        if (data_cnt_q == len_q) begin
                            poll_phase_d = 1'b1;
                            state_d      = StGap;
                        end
                    end
                end else begin
                    if (spi_done && !last_q) begin
                        if (data_cnt_q == len_q) last_d = 1'b1;
                        else data_cnt_d = data_cnt_q + 1'b1;
                    end
                    // Hold CS until the final byte has been taken by the engine.
                    if (rd_last && !rx_stall) state_d = StFin;
                end
            end
            StPollCmd: if (byte_fire) state_d = StPollRd;
            StPollRd: begin
                if (spi_done) begin
                    if (!spi_rx_data[0]) begin
                        state_d = StFin;
                    end else if (poll_cnt_q == 16'(POLL_MAX - 1)) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            len_q        <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            poll_phase_q <= 1'b0;
            last_q       <= 1'b0;
            tx_sent_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            byte_cnt_q   <= '0;
            data_cnt_q   <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            poll_phase_q <= poll_phase_d;
            last_q       <= last_d;
            tx_sent_q    <= tx_sent_d;
            req_ready_q  <= (state_d == StIdle);
            byte_cnt_q   <= byte_cnt_d;
            data_cnt_q   <= data_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err       = err_q;
    assign spi_start = (state_q != StIdle) && (state_q != StGap) && (state_q != StFin);
    assign spi_qed   = QuadRead && !wr_q &&
                       (state_q inside {StCmd, StAddr, StDummy, StData});
    assign spi_quad  = QuadRead && !wr_q && (state_q == StData);

endmodule

// File: tb/tb_mem_txn_fsm.sv
// Directed bench for mem_txn_fsm with a byte-level model of mem_spi_controller and a flash status reg.
module tb_mem_txn_fsm;
    localparam int unsigned GAP  = 4;
    localparam int unsigned PMAX = 8;
`ifdef MEM_QUAD_READ_EN
    localparam bit         QUAD  = 1'b1;
    localparam logic [7:0] RD_OP = 8'h6B;
`else
    localparam bit         QUAD  = 1'b0;
    localparam logic [7:0] RD_OP = 8'h03;
`endif
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        req_ready, busy, done, err;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [7:0]  wr_data, rd_data;
    logic        spi_start, spi_r_w, spi_quad, spi_qed;
    logic        spi_done, spi_tx_valid, spi_tx_ready, spi_rx_valid, spi_rx_ready;
    logic [7:0]  spi_tx_data, spi_rx_data;

    int n_vec = 0;
    int n_bad = 0;
    bit cur_wr = 1'b0;
    bit rd_mode = 1'b0;
    int rx_budget = 0;
    int wip_ones = 0;

    mem_txn_fsm #(.CS_GAP_CYC(GAP), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err), .spi_start(spi_start), .spi_r_w(spi_r_w),
        .spi_quad(spi_quad), .spi_qed(spi_qed), .spi_done(spi_done),
        .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_rx_ready(spi_rx_ready)
    );

    always #5 clk = ~clk;

    // Engine side: fixed write-data source and optional toggling read backpressure.
    logic [7:0] wr_buf [0:3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    int   wr_idx = 0;
    logic tog = 1'b0;
    assign wr_valid = 1'b1;
    assign wr_data  = wr_buf[wr_idx[1:0]];
    assign rd_ready = rd_mode ? tog : 1'b1;
    always @(posedge clk) begin
        tog <= ~tog;
        if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
    end

    // Controller model: each byte takes 3 cycles, rx bytes wait to be consumed before the next.
    bq_t tx_log, rd_log;
    int  gaps[$];
    int  m_cnt, rx_used;
    bit  m_rx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_done     <= 1'b0;
            spi_tx_ready <= 1'b1;
            spi_rx_valid <= 1'b0;
            spi_rx_data  <= 8'h00;
            m_cnt        <= 0;
            m_rx         <= 1'b0;
            rx_used      <= 0;
        end else begin
            spi_done <= 1'b0;
            if (spi_rx_valid && spi_rx_ready) spi_rx_valid <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    spi_done     <= 1'b1;
                    spi_tx_ready <= 1'b1;
                    if (m_rx) begin
                        spi_rx_valid <= 1'b1;
                        spi_rx_data  <= cur_wr ? ((rx_used < wip_ones) ? 8'h01 : 8'h00)
                                               : (8'(rx_used) ^ 8'h5C);
                        rx_used      <= rx_used + 1;
                    end
                end
            end else if (spi_tx_valid && spi_tx_ready) begin
                tx_log.push_back(spi_tx_data);
                spi_tx_ready <= 1'b0;
                m_cnt        <= 2;
                m_rx         <= 1'b0;
            end else if (spi_start && spi_r_w && !spi_rx_valid && !spi_done &&
                         rx_used < rx_budget) begin
                m_cnt <= 2;
                m_rx  <= 1'b1;
            end
            if (!spi_start) rx_used <= 0;
        end
    end

    bit start_q = 1'b0;
    int low_run = 0, cs_rises = 0, rx_hs = 0, quad_cyc = 0, quad_bad = 0, qed_cyc = 0;
    always @(posedge clk) begin
        start_q <= spi_start;
        low_run <= (!spi_start && busy) ? low_run + 1 : 0;
        if (spi_start && !start_q) begin
            cs_rises <= cs_rises + 1;
            if (low_run > 0) gaps.push_back(low_run);
        end
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        if (spi_rx_valid && spi_rx_ready) rx_hs <= rx_hs + 1;
        if (spi_quad) quad_cyc <= quad_cyc + 1;
        if (spi_quad && !(spi_start && spi_r_w)) quad_bad <= quad_bad + 1;
        if (spi_qed) qed_cyc <= qed_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tx(input string tag, input int base, input bq_t exp);
        int bad = 0;
        chk({tag, "_txcnt"}, 32'(tx_log.size() - base), 32'(exp.size()));
        foreach (exp[i])
            if (base + i >= tx_log.size() || tx_log[base + i] !== exp[i]) bad++;
        chk({tag, "_txbytes"}, 32'(bad), 32'd0);
    endtask

    task automatic check_rd(input string tag, input int base, input int n);
        int bad = 0;
        chk({tag, "_rdcnt"}, 32'(rd_log.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            if (base + i >= rd_log.size() || rd_log[base + i] !== (8'(i) ^ 8'h5C)) bad++;
        chk({tag, "_rdbytes"}, 32'(bad), 32'd0);
    endtask

    function automatic bq_t rd_exp(input logic [23:0] a);
        bq_t e = {RD_OP, a[23:16], a[15:8], a[7:0]};
        if (QUAD) e.push_back(8'h00);
        return e;
    endfunction

    task automatic issue(input bit wr, input logic [23:0] a, input logic [7:0] l, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        cur_wr    = wr;
        req_wr    = wr;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [23:0] a, input logic [7:0] l);
        int tb = tx_log.size();
        int rb = rd_log.size();
        int cb = cs_rises;
        rx_budget = int'(l) + 1;
        issue(1'b0, a, l, tag);
        wait_done(tag);
        chk({tag, "_err"}, 32'(err), 32'd0);
        check_tx(tag, tb, rd_exp(a));
        check_rd(tag, rb, int'(l) + 1);
        chk({tag, "_cs"}, 32'(cs_rises - cb), 32'd1);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    task automatic do_write(input string tag, input logic [23:0] a, input logic [7:0] l,
                            input bq_t wd, input int wips, input int reads, input bit exp_err);
        int  tb = tx_log.size();
        int  cb = cs_rises;
        int  gb = gaps.size();
        int  hb = rx_hs;
        bq_t e  = {8'h06, 8'h02, a[23:16], a[15:8], a[7:0]};
        foreach (wd[i]) e.push_back(wd[i]);
        e.push_back(8'h05);
        rx_budget = 1000;
        wip_ones  = wips;
        issue(1'b1, a, l, tag);
        wait_done(tag);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        check_tx(tag, tb, e);
        chk({tag, "_status_reads"}, 32'(rx_hs - hb), 32'(reads));
        chk({tag, "_cs"}, 32'(cs_rises - cb), 32'd3);
        chk({tag, "_ngaps"}, 32'(gaps.size() - gb), 32'd2);
        chk({tag, "_gap0"}, 32'((gaps.size() > gb) ? gaps[gb] : -1), 32'(GAP));
        chk({tag, "_gap1"}, 32'((gaps.size() > gb + 1) ? gaps[gb + 1] : -1), 32'(GAP));
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    initial begin
        int tb, n, qb;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {24'd0, req_ready, busy, done, err, spi_start, spi_tx_valid,
                            rd_valid, wr_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        do_read("t1_read", 24'h012345, 8'd3);
        do_write("t2_write", 24'h000100, 8'd1, '{8'hA5, 8'h5A}, 3, 4, 1'b0);
        do_write("t3_timeout", 24'h000200, 8'd0, '{8'hC3}, 1000, int'(PMAX), 1'b1);
        rd_mode = 1'b1;
        do_read("t4_read256", 24'h000000, 8'd255);
        rd_mode = 1'b0;

        qb = quad_cyc;
        do_read("t5_read1", 24'h000000, 8'd0);
        chk("t5_quad_used", 32'(quad_cyc != qb), 32'(QUAD));

        tb = tx_log.size();
        rx_budget = 8;
        issue(1'b0, 24'h0ABCDE, 8'd7, "t6_abort");
        n = 0;
        while (tx_log.size() < tb + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_addr", 32'(tx_log.size() - tb), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 32'(spi_start), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready", 32'(req_ready), 32'd1);
        do_read("t6_read", 24'h0000AB, 8'd1);

        chk("quad_outside_data", 32'(quad_bad), 32'd0);
        chk("qed_used", 32'(qed_cyc != 0), 32'(QUAD));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
